// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline boundary registers: bundle widths,
// control-field bit positions and the stage-register occupancy encoding.
package pipe_pkg;

  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 133;  // aluout, writedata, writereg, a0, v0
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 165;  // readdata, aluout, writereg, a0, v0, instr

  localparam int CTRL_SYSCALL  = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWRITE = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat carrying one control bundle and one data bundle.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 133
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline boundary register with handshake, stall, flush, optional
// skid entry and hazard taps.
//   state | meaning
//   EMPTY | no entry held
//   ONE   | main entry valid
//   TWO   | main and skid entries valid (SKID=1 only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int HZ_W   = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  input  logic              stall,
  input  logic              flush,
  output logic [HZ_W-1:0]   hz_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              rst_done_q, rst_done_d;
  logic [HZ_W-1:0]   hz_q, hz_d;

  logic              out_valid_w, in_ready_w, in_xfer, out_xfer;
  logic [CTRL_W-1:0] out_ctrl_w;

  assign out_valid_w = (state_q != EMPTY) & ~stall;
  assign out_ctrl_w  = out_valid_w ? main_ctrl_q : '0;

  // A flush always takes the offered beat so upstream never blocks on a squash.
  always_comb begin
    if (SKID != 0)
      in_ready_w = rst_done_q & (flush | (in_ready_q & ~stall));
    else
      in_ready_w = rst_done_q & (flush | ((~out_valid_w | dn.ready) & ~stall));
  end

  assign in_xfer  = up.valid & in_ready_w;
  assign out_xfer = out_valid_w & dn.ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    rst_done_d  = 1'b1;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = ONE;
            main_ctrl_d = up.ctrl;
            main_data_d = up.data;
          end
        end
        ONE: begin
          if (in_xfer && (out_xfer || (SKID == 0))) begin
            main_ctrl_d = up.ctrl;
            main_data_d = up.data;
          end else if (in_xfer) begin
            state_d     = TWO;
            skid_ctrl_d = up.ctrl;
            skid_data_d = up.data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO) & ~stall;
    hz_d       = out_ctrl_w[HZ_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b0;
      rst_done_q  <= 1'b0;
      hz_q        <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      rst_done_q  <= rst_done_d;
      hz_q        <= hz_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid_w & ~stall),
    .clear (1'b0),
    .cnt   (bubble_cnt)
  );

  assign up.ready = in_ready_w;
  assign dn.valid = out_valid_w;
  assign dn.ctrl  = out_ctrl_w;
  assign dn.data  = main_data_q;
  assign hz_ctrl  = hz_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 (A), SKID=0 (B) and CNT_W=3 (C) share one
// stimulus; A and B each have a scoreboard of accepted beats.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = EXMEM_CTRL_W;
  localparam int DW = EXMEM_DATA_W;
  localparam logic [CW-1:0] CTRL_STREAM = CW'((1 << CTRL_REGWRITE) | (1 << CTRL_MEMTOREG));
  localparam logic [CW-1:0] CTRL_ALL    = CW'((1 << CTRL_SYSCALL) | (1 << CTRL_REGWRITE) |
                                              (1 << CTRL_MEMTOREG) | (1 << CTRL_MEMWRITE));
  typedef logic [CW+DW-1:0] beat_t;

  logic          clk, rst_n;
  logic          in_valid, out_ready, stall, flush;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic [1:0]  a_hz, b_hz, c_hz;
  logic [15:0] a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt;
  logic [2:0]  c_stall_cnt, c_bubble_cnt;

  int n_vec = 0;
  int n_err = 0;
  beat_t qa[$];
  beat_t qb[$];

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) a_up(), a_dn(), b_up(), b_dn(), c_up(), c_dn();

  assign a_up.valid = in_valid; assign a_up.ctrl = in_ctrl; assign a_up.data = in_data;
  assign b_up.valid = in_valid; assign b_up.ctrl = in_ctrl; assign b_up.data = in_data;
  assign c_up.valid = in_valid; assign c_up.ctrl = in_ctrl; assign c_up.data = in_data;
  assign a_dn.ready = out_ready;
  assign b_dn.ready = out_ready;
  assign c_dn.ready = out_ready;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .HZ_W(2), .SKID(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .up(a_up), .dn(a_dn), .stall(stall), .flush(flush),
    .hz_ctrl(a_hz), .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .HZ_W(2), .SKID(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .up(b_up), .dn(b_dn), .stall(stall), .flush(flush),
    .hz_ctrl(b_hz), .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .HZ_W(2), .SKID(1), .CNT_W(3)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .up(c_up), .dn(c_dn), .stall(stall), .flush(flush),
    .hz_ctrl(c_hz), .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transfers sampled mid-cycle are the ones the next rising edge commits.
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
    end else begin
      if (a_dn.valid && a_dn.ready) begin
        if (qa.size() == 0) chk("A_extra_beat", qa.size(), 1);
        else chk("A_out_beat", {a_dn.ctrl, a_dn.data}, qa.pop_front());
      end else if (!a_dn.valid) begin
        chk("A_ctrl_mask", a_dn.ctrl, 0);
      end
      if (flush) qa.delete();
      else if (a_up.valid && a_up.ready) qa.push_back({in_ctrl, in_data});
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb.delete();
    end else begin
      if (b_dn.valid && b_dn.ready) begin
        if (qb.size() == 0) chk("B_extra_beat", qb.size(), 1);
        else chk("B_out_beat", {b_dn.ctrl, b_dn.data}, qb.pop_front());
      end
      if (flush) qb.delete();
      else if (b_up.valid && b_up.ready) qb.push_back({in_ctrl, in_data});
    end
  end

  // Offers n beats, holding each until A accepts it.
  task automatic drive_beats(input int base, input int n, input logic [CW-1:0] ctrl,
                             input int rdy_at);
    int  idx;
    logic acc;
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < n; cyc++) begin
      in_valid  = 1'b1;
      in_ctrl   = ctrl;
      in_data   = DW'(base + idx);
      out_ready = (cyc >= rdy_at);
      @(negedge clk);
      acc = a_up.ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("drive_accepted", idx, n);
  endtask

  initial begin
    int   idx;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    in_ctrl = '0; in_data = '0;
    #1;
    chk("rst_in_ready", a_up.ready, 0);
    chk("rst_out_valid", a_dn.valid, 0);
    chk("rst_out_data", a_dn.data, 0);
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", a_up.ready, 0);
    step();
    chk("rel_ready_after_edge", a_up.ready, 1);
    chk("rel_b_ready_after_edge", b_up.ready, 1);
    repeat (9) step();
    chk("bubble_cnt_10", a_bubble_cnt, 10);
    chk("bubble_cnt_sat3", c_bubble_cnt, 7);
    chk("stall_cnt_idle", a_stall_cnt, 0);

    // back-to-back stream
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_ctrl = CTRL_STREAM; in_data = DW'(k); out_ready = 1'b1;
      step();
      chk("A_stream_ov", a_dn.valid, 1);
      chk("B_stream_ov", b_dn.valid, 1);
      chk("A_stream_data", a_dn.data, k);
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("A_stream_drained", qa.size(), 0);
    chk("B_stream_drained", qb.size(), 0);

    // backpressure: 3 beats offered with out_ready low for 3 cycles
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid  = (idx < 3);
      in_ctrl   = 4'b0011;
      in_data   = DW'(100 + idx);
      out_ready = (cyc >= 3);
      @(negedge clk);
      if (cyc == 2) begin
        chk("bp_accepted_two", idx, 2);
        chk("bp_ready_in_two", a_up.ready, 0);
        chk("bp_head_data", a_dn.data, 100);
      end
      acc = in_valid & a_up.ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", idx, 3);
    chk("bp_drained", qa.size(), 0);

    // stall for two cycles while holding one beat
    in_valid = 1'b1; in_ctrl = CTRL_ALL; in_data = DW'(200); out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_ov", a_dn.valid, 0);
      chk("stall_ctrl", a_dn.ctrl, 0);
      chk("stall_ready", a_up.ready, 0);
      step();
    end
    stall = 1'b0; out_ready = 1'b1;
    #1;
    chk("stall_cnt_2", a_stall_cnt, 2);
    chk("stall_cnt_2_b", b_stall_cnt, 2);
    chk("post_stall_ov", a_dn.valid, 1);
    chk("post_stall_ctrl", a_dn.ctrl, CTRL_ALL);
    chk("post_stall_data", a_dn.data, 200);
    chk("hz_during_stall", a_hz, 0);
    step();
    chk("hz_after_beat", a_hz, 2'b11);
    repeat (2) step();

    // flush together with stall while two entries are held
    drive_beats(300, 2, 4'b0101, 99);
    chk("two_in_ready", a_up.ready, 0);
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_ctrl = CTRL_ALL; in_data = DW'(399);
    step();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_ov", a_dn.valid, 0);
    chk("flush_stall_cnt", a_stall_cnt, 3);
    step();
    chk("flush_ov_next", a_dn.valid, 0);
    chk("flush_hz", a_hz, 0);
    repeat (2) step();
    chk("flush_q_empty", qa.size(), 0);

    // asynchronous reset while two entries are held
    drive_beats(500, 2, 4'b1010, 99);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", a_dn.valid, 0);
    chk("midrst_ctrl", a_dn.ctrl, 0);
    chk("midrst_data", a_dn.data, 0);
    chk("midrst_ready", a_up.ready, 0);
    chk("midrst_cnts", {a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt,
                        c_stall_cnt, c_bubble_cnt}, 0);
    chk("midrst_hz", {a_hz, b_hz, c_hz}, 0);
    out_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready_pre", a_up.ready, 0);
    step();
    chk("midrst_rel_ready", a_up.ready, 1);
    chk("midrst_rel_ov", a_dn.valid, 0);
    repeat (2) step();
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that generalises the fixed-field stage registers (EX/MEM, MEM/WB) into one reusable block.
- Carries a control bundle and a data bundle between two stages.
- Uses a valid/ready handshake, stall and flush (bubble insertion), an optional skid entry for full throughput with a registered in_ready, and registered hazard-unit taps.
- Instantiated once per pipeline boundary; field packing and unpacking is done by the wrapper at each stage.

Parameters:
- CTRL_W, 4: width of the control bundle (syscall, regwrite, memtoreg, memwrite, ...). All bits are forced to 0 in a bubble.
- DATA_W, 133: width of the data bundle (aluout, writedata, writereg, a0, v0, instr, ...). Holds its value in a bubble.
- HZ_W, 2: number of low control bits mirrored to the hazard taps.
- SKID, 1: 1 adds a second entry with a registered in_ready; 0 gives a single entry with a combinational in_ready.
- CNT_W, 16: width of the stall and bubble statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- stall  in  1  hazard-unit freeze of this stage.
- flush  in  1  hazard-unit squash of this stage.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control bundle; 0 when out_valid=0.
- out_data  out  DATA_W  head data bundle.
- hz_ctrl  out  HZ_W  registered copy of out_ctrl[HZ_W-1:0], for the hazard unit.
- stall_cnt  out  CNT_W  count of cycles with stall=1.
- bubble_cnt  out  CNT_W  count of cycles with out_valid=0 and stall=0.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - all valid bits 0; out_ctrl, hz_ctrl, stall_cnt and bubble_cnt are 0; out_data is 0.
  - in_ready is 0 during reset and becomes 1 on the first clk edge after release.
  - Reset mid-operation discards all entries.
- Transfer rules:
  - Input transfer happens when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
  - Latency from input transfer to out_valid is 1 cycle.
  - No combinational path from in_* to out_*.
- States when SKID=1: EMPTY, ONE (main entry valid), TWO (main and skid entries valid).
  - EMPTY -> ONE on an input transfer.
  - ONE -> EMPTY on an output transfer with no input transfer.
  - ONE stays ONE on simultaneous input and output transfers; main is loaded with the new beat.
  - ONE -> TWO on an input transfer with no output transfer; the beat goes to skid.
  - TWO -> ONE on an output transfer; skid moves to main.
  - in_ready is registered, equal to (state != TWO) & !stall_next, where stall_next is the stall value sampled at the last edge. A beat offered while TWO is not accepted.
- When SKID=0: in_ready = (!out_valid | out_ready) & !stall, combinational. States are EMPTY and ONE only.
- Stall:
  - in_ready is forced 0 and out_valid is forced 0, so no transfer happens in either direction.
  - Entries hold; out_ctrl reads 0 while stalled; stall_cnt increments.
- Flush:
  - On the edge where flush=1, all entries are invalidated and the control registers are loaded with 0.
  - Any beat offered that cycle is accepted, so upstream is not blocked, and then discarded.
  - out_valid is 0 on the next cycle.
  - Flush and stall together: flush wins, state goes to EMPTY, and stall_cnt still increments.
- out_ctrl is masked: it is 0 whenever the head entry is invalid. hz_ctrl equals out_ctrl[HZ_W-1:0] delayed by 1 cycle.
- Counters: saturate at 2^CNT_W-1; they do not wrap.
- Data: out_data is never masked; a bubble shows the last valid payload. Every data bit passes through unmodified; no field is fed back onto itself.

Decomposition:
- Shared package pipe_pkg holds:
  - the CTRL_W/DATA_W constants per boundary (EXMEM_CTRL_W=4, EXMEM_DATA_W=133, MEMWB_...);
  - the bit-index constants of the ctrl fields (CTRL_SYSCALL=0, CTRL_REGWRITE=1, CTRL_MEMTOREG=2, CTRL_MEMWRITE=3);
  - the state encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- One sub-module is natural: sat_counter (width CNT_W; inc, clear, saturating), instantiated twice.

Test Plan:
- Reset with rst_n=0 mid-stream while in state TWO -> out_valid=0 and out_ctrl=0 immediately; stall_cnt=0; in_ready=1 one edge after release.
- Back-to-back stream of 8 beats, ctrl=4'b0110, data=k, with out_ready=1 -> out_valid continuous from cycle 1; data 0..7 in order, one per cycle, for SKID=1 and for SKID=0.
- Backpressure: out_ready=0 for 3 cycles while 3 beats are offered (SKID=1) -> 2 beats accepted and in_ready=0 in TWO; on release, beats drain in order with none lost or duplicated.
- Stall=1 for 2 cycles in state ONE with ctrl=4'b1111 -> out_valid=0, out_ctrl=0, stall_cnt=2; the same beat appears with ctrl=4'b1111 after stall drops.
- Flush=1 and stall=1 together in state TWO with in_valid=1 -> next cycle EMPTY and out_valid=0; the offered beat never appears; hz_ctrl=0 one cycle later.
- Saturation with CNT_W=3: 10 bubble cycles -> bubble_cnt stops at 7.
